// File: rtl/uart_pkg.sv
// Shared UART framing defaults and the receiver state encoding.
package uart_pkg;

  localparam int NBITS       = 8;
  localparam int STPBITS     = 2;
  localparam int FINAL_TICKS = 16;
  localparam int FINAL_TIME  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick divider: one tick every final_time+1 enabled clocks.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int final_time = FINAL_TIME
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [3:0] cnt_last = 4'(final_time);

  logic [3:0] cnt;

  assign tick = en & (cnt == cnt_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (!en || clr || tick) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, MSB-first data,
// parallel word out with a one-cycle done strobe and framing-error flag.
//
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line
//   START | timing to mid start bit, rejecting glitches
//   DATA  | sampling nbits data bits at mid-bit
//   STOP  | sampling stpbits stop bits, then publishing the word
module uart_rx
  import uart_pkg::*;
#(
  parameter int nbits       = NBITS,
  parameter int stpbits     = STPBITS,
  parameter int final_ticks = FINAL_TICKS,
  parameter int final_time  = FINAL_TIME
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [nbits-1:0] rx_dout,
  output logic             rx_done,
  output logic             framing_err,
  output logic             rx_busy
);

  localparam int bcnt_w = $clog2(nbits + 1);
  localparam logic [3:0]        s_mid     = 4'(final_ticks / 2 - 1);
  localparam logic [3:0]        s_last    = 4'(final_ticks - 1);
  localparam logic [bcnt_w-1:0] data_last = bcnt_w'(nbits - 1);
  localparam logic [bcnt_w-1:0] stop_last = bcnt_w'(stpbits - 1);
  localparam logic [bcnt_w-1:0] bcnt_one  = bcnt_w'(1);

  rx_state_t         state;
  logic              sync1, rx_s, rx_p;
  logic              tick, fall, tick_clr;
  logic [3:0]        s_cnt;
  logic [bcnt_w-1:0] b_cnt;
  logic [nbits-1:0]  shreg;
  logic              err_sticky;

  // Requiring rx_p=1 means a held-low line (break) cannot retrigger.
  assign fall     = rx_p & ~rx_s;
  assign tick_clr = (state == IDLE) & fall;
  assign rx_busy  = (state != IDLE);

  uart_tick_gen #(.final_time(final_time)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (rx_busy),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_p  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      rx_p  <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      s_cnt       <= 4'd0;
      b_cnt       <= '0;
      shreg       <= '0;
      err_sticky  <= 1'b0;
      rx_dout     <= '0;
      rx_done     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            s_cnt <= 4'd0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == s_mid) begin
              s_cnt <= 4'd0;
              if (!rx_s) begin
                b_cnt <= '0;
                state <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == s_last) begin
              shreg <= {shreg[nbits-2:0], rx_s};
              if (b_cnt == data_last) begin
                b_cnt <= '0;
                state <= STOP;
              end else begin
                b_cnt <= b_cnt + bcnt_one;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == s_last) begin
              // The last half stop bit is left unconsumed so back-to-back frames fit.
              if (b_cnt == stop_last) begin
                rx_dout     <= shreg;
                framing_err <= err_sticky | ~rx_s;
                rx_done     <= 1'b1;
                err_sticky  <= 1'b0;
                b_cnt       <= '0;
                state       <= IDLE;
              end else begin
                err_sticky <= err_sticky | ~rx_s;
                b_cnt      <= b_cnt + bcnt_one;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, corner sequences
// and randomized frames against a frame-level reference model.
module tb_uart_rx;

  localparam int BIT_CLKS  = 160;
  // Line fall to done strobe: 2 sync clocks + detect edge + 168 ticks of 10 clocks.
  localparam int DONE_LAT  = 1683;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_dout;
  logic       rx_done;
  logic       framing_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_dout     (rx_dout),
    .rx_done     (rx_done),
    .framing_err (framing_err),
    .rx_busy     (rx_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] dout;
    logic       ferr;
    int         at;
  } pulse_t;

  pulse_t got_q[$];
  pulse_t exp_q[$];

  always @(negedge clk) begin
    if (rx_done) got_q.push_back('{rx_dout, framing_err, cyc});
  end

  typedef struct {
    logic [7:0] d;
    logic [1:0] stp;
    int         last_len;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  // stp[1] is the first stop bit, stp[0] the second.
  task automatic send(input logic [7:0] d, input logic [1:0] stp, input int last_len,
                      output int fall);
    fall = cyc;
    hold(1'b0, BIT_CLKS);
    for (int i = 7; i >= 0; i--) hold(d[i], BIT_CLKS);
    hold(stp[1], BIT_CLKS);
    hold(stp[0], last_len);
  endtask

  task automatic check_pulses(input string tag);
    for (int i = 0; i < 4000 && got_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (5) @(negedge clk);
    cmp({tag, "_pulse_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      cmp($sformatf("%s_dout[%0d]", tag, i), got_q[i].dout, exp_q[i].dout);
      cmp($sformatf("%s_ferr[%0d]", tag, i), got_q[i].ferr, exp_q[i].ferr);
      cmp($sformatf("%s_done_cycle[%0d]", tag, i), got_q[i].at, exp_q[i].at);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fall, fall_prev, gap_got;
    logic [7:0] d;
    logic [1:0] stp;

    vecs[0] = '{8'hA5, 2'b11, BIT_CLKS, 20, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 2'b10, BIT_CLKS, 20, 8'h3C, 1'b1};
    vecs[2] = '{8'h81, 2'b11, BIT_CLKS, 20, 8'h81, 1'b0};
    vecs[3] = '{8'h00, 2'b11, 81,       0,  8'h00, 1'b0};
    vecs[4] = '{8'hFF, 2'b11, BIT_CLKS, 20, 8'hFF, 1'b0};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    cmp("reset_dout", rx_dout, 0);
    cmp("reset_done", rx_done, 0);
    cmp("reset_ferr", framing_err, 0);
    cmp("reset_busy", rx_busy, 0);
    reset = 1'b0;
    hold(1'b1, 10);

    // Directed table; entry 3 cuts its stop bit so entry 4 starts at D+1681.
    fall_prev = 0;
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].d, vecs[v].stp, vecs[v].last_len, fall);
      exp_q.push_back('{vecs[v].exp_dout, vecs[v].exp_ferr, fall + DONE_LAT});
      if (vecs[v].gap > 0) hold(1'b1, vecs[v].gap);
      if (v == 4) gap_got = fall - fall_prev;
      fall_prev = fall;
    end
    cmp("b2b_start_spacing", gap_got, 1681);
    check_pulses("table");

    // Glitch: low for 30 clocks, rejected at the mid start-bit check.
    fall = cyc;
    hold(1'b0, 30);
    hold(1'b1, 52);
    cmp("glitch_busy_before_check", rx_busy, 1);
    @(negedge clk);
    cmp("glitch_busy_after_check", rx_busy, 0);
    hold(1'b1, 100);
    check_pulses("glitch");
    cmp("glitch_dout_kept", rx_dout, 8'hFF);

    // Reset during data bit 3 of 0x5A.
    hold(1'b0, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b1, 60);
    reset = 1'b1;
    #1;
    cmp("midreset_dout", rx_dout, 0);
    cmp("midreset_busy", rx_busy, 0);
    cmp("midreset_done", rx_done, 0);
    cmp("midreset_ferr", framing_err, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hold(1'b1, 40);
    send(8'h5A, 2'b11, BIT_CLKS, fall);
    exp_q.push_back('{8'h5A, 1'b0, fall + DONE_LAT});
    hold(1'b1, 20);
    check_pulses("after_reset");

    // Break: held low far longer than a frame; one errored frame, no retrigger.
    fall = cyc;
    hold(1'b0, 5000);
    exp_q.push_back('{8'h00, 1'b1, fall + DONE_LAT});
    cmp("break_busy_while_low", rx_busy, 0);
    hold(1'b1, 100);
    cmp("break_busy_after_high", rx_busy, 0);
    check_pulses("break");

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 12; n++) begin
      d      = 8'($urandom_range(0, 255));
      stp[1] = ($urandom_range(0, 3) != 0);
      stp[0] = ($urandom_range(0, 3) != 0);
      send(d, stp, BIT_CLKS, fall);
      exp_q.push_back('{d, ~(stp[1] & stp[0]), fall + DONE_LAT});
      hold(1'b1, $urandom_range(2, 40));
    end
    check_pulses("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
